attn_result_collector: RTL



---
 rtl/attn_pkg.sv | 16 +
 rtl/attn_result_buf.sv | 26 ++
 rtl/attn_result_collector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/attn_pkg.sv
// Shared types and defaults for the attention result path.
package attn_pkg;

  localparam int ATTN_DATA_W = 18;
  localparam int ATTN_ROWS   = 8;
  localparam int ATTN_COLS   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } attn_state_t;

  typedef logic [ATTN_DATA_W-1:0] attn_elem_t;

endpackage

// File: rtl/attn_result_buf.sv
// Result matrix storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the collector never exposes unwritten entries.
module attn_result_buf #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/attn_result_collector.sv
// Captures the non-stallable answer/done stream into a matrix buffer and replays it
// row-major on valid/ready with row/matrix framing. ATTN_ROW_SUM_EN adds per-row sums.
module attn_result_collector
  import attn_pkg::*;
#(
  parameter int DATA_W = ATTN_DATA_W,
  parameter int ROWS   = ATTN_ROWS,
  parameter int COLS   = ATTN_COLS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_answer,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
`ifdef ATTN_ROW_SUM_EN
  ,
  output logic [DATA_W+$clog2(COLS)-1:0] out_row_sum
`endif
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  attn_state_t       state_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [CW-1:0]     rd_cnt_q;
  logic              done_q;
  logic              overflow_q;

  logic              start;
  logic              buf_we;
  logic [AW-1:0]     buf_waddr;
  logic [DATA_W-1:0] buf_rdata;

  assign start = in_done & ~done_q;

  // Element 0 arrives in the same cycle as the start event, so IDLE writes address 0.
  assign buf_we    = ((state_q == IDLE) && start) || (state_q == CAPTURE);
  assign buf_waddr = (state_q == CAPTURE) ? wr_cnt_q[AW-1:0] : '0;

  attn_result_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (in_answer),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= in_done;
      if (start && (state_q != IDLE)) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            wr_cnt_q <= CW'(1);
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          wr_cnt_q <= wr_cnt_q + CW'(1);
          if (wr_cnt_q == CW'(DEPTH - 1)) begin
            rd_cnt_q <= '0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
            if (rd_cnt_q == CW'(DEPTH - 1)) begin
              rd_cnt_q <= '0;
              wr_cnt_q <= '0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = (state_q == DRAIN);
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign out_data     = out_valid ? buf_rdata : '0;
  assign out_row_last = out_valid && ((rd_cnt_q % CW'(COLS)) == CW'(COLS - 1));
  assign out_last     = out_valid && (rd_cnt_q == CW'(DEPTH - 1));

`ifdef ATTN_ROW_SUM_EN
  localparam int SW = DATA_W + $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [SW-1:0] row_sum_q [ROWS];
  logic [RW-1:0] wr_row;
  logic [RW-1:0] rd_row;

  assign wr_row = RW'(wr_cnt_q / CW'(COLS));
  assign rd_row = RW'(rd_cnt_q / CW'(COLS));

  // Sums restart on every accepted start so a row total never mixes two matrices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        row_sum_q[r] <= '0;
      end
    end else if ((state_q == IDLE) && start) begin
      for (int r = 0; r < ROWS; r++) begin
        row_sum_q[r] <= '0;
      end
      row_sum_q[0] <= SW'(in_answer);
    end else if (state_q == CAPTURE) begin
      row_sum_q[wr_row] <= row_sum_q[wr_row] + SW'(in_answer);
    end
  end

  assign out_row_sum = out_valid ? row_sum_q[rd_row] : '0;
`endif

endmodule
